// File: rtl/adder_rr_arbiter_pkg.sv
// Shared constants and helpers for the round-robin shared-adder arbiter.
package adder_rr_arbiter_pkg;

  localparam int NREQ_DEF  = 4;
  localparam int WIDTH_DEF = 4;
  localparam int IDW_DEF   = 2;

  // Index reached by stepping 'step' places past 'cur' on a ring of 'n' lanes.
  function automatic int ring_idx(input int cur, input int step, input int n);
    return (cur + step) % n;
  endfunction

endpackage

// File: rtl/adder_rr_arbiter_rr_grant.sv
// Combinational round-robin priority: the first valid lane after ptr wins.
module rr_grant
  import adder_rr_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IDW  = IDW_DEF
) (
  input  logic [NREQ-1:0] req_valid,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx,
  output logic            any_grant
);

  // Walk the ring starting one past the last granted lane; lane ptr itself is
  // visited last, so a lone requester is still granted every cycle.
  always_comb begin
    int idx;
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = ring_idx(int'(ptr), k, NREQ);
      if (!any_grant && req_valid[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = IDW'(idx);
        any_grant  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fulladder.sv
// One-bit full adder cell used to build ripple-carry chains.
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/adder_rr_arbiter.sv
// One ripple-carry adder shared round-robin among NREQ partial-sum lanes,
// feeding a single tagged result register with valid/ready handshake.
module adder_rr_arbiter
  import adder_rr_arbiter_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int IDW   = IDW_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       req_ready,
  output logic                  resp_valid,
  output logic [IDW-1:0]        resp_id,
  output logic [WIDTH-1:0]      resp_sum,
  output logic                  resp_cout,
  input  logic                  resp_ready
);

  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   grant_idx;
  logic             any_grant;
  logic [IDW-1:0]   ptr;
  logic             slot_free;
  logic             accept;

  logic [WIDTH-1:0] a_p0;
  logic [WIDTH-1:0] b_p0;
  logic [WIDTH-1:0] sum_p0;
  logic [WIDTH:0]   carry_p0;

  logic             vld_p1;
  logic [IDW-1:0]   id_p1;
  logic [WIDTH-1:0] sum_p1;
  logic             cout_p1;

  rr_grant #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_grant (
    .req_valid (req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  // The slot can take a new result when empty or when it drains this cycle;
  // rst masks ready so nothing is handshaken while the block is being cleared.
  assign slot_free = !vld_p1 || resp_ready;
  assign req_ready = (slot_free && !rst && any_grant) ? grant : '0;
  assign accept    = |req_ready;

  // Stage p0: route the granted lane's operands into the shared adder.
  always_comb begin
    a_p0 = req_a[int'(grant_idx)*WIDTH +: WIDTH];
    b_p0 = req_b[int'(grant_idx)*WIDTH +: WIDTH];
  end

  assign carry_p0[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
    fulladder u_fa (
      .a    (a_p0[i]),
      .b    (b_p0[i]),
      .cin  (carry_p0[i]),
      .s    (sum_p0[i]),
      .cout (carry_p0[i+1])
    );
  end

  // Stage p1 control: slot occupancy and the round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      ptr    <= IDW'(NREQ - 1);
    end else if (accept) begin
      vld_p1 <= 1'b1;
      ptr    <= grant_idx;
    end else if (resp_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  // Stage p1 data: result fields load on accept and otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_p1   <= '0;
      sum_p1  <= '0;
      cout_p1 <= 1'b0;
    end else if (accept) begin
      id_p1   <= grant_idx;
      sum_p1  <= sum_p0;
      cout_p1 <= carry_p0[WIDTH];
    end
  end

  assign resp_valid = vld_p1;
  assign resp_id    = id_p1;
  assign resp_sum   = sum_p1;
  assign resp_cout  = cout_p1;

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Randomized and directed bench for adder_rr_arbiter against a ring-search
// reference model of the arbiter and result slot.
module tb_adder_rr_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 4;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_ready;
  logic                  resp_valid;
  logic [IDW-1:0]        resp_id;
  logic [WIDTH-1:0]      resp_sum;
  logic                  resp_cout;
  logic                  resp_ready;

  adder_rr_arbiter #(
    .NREQ  (NREQ),
    .WIDTH (WIDTH),
    .IDW   (IDW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_sum   (resp_sum),
    .resp_cout  (resp_cout),
    .resp_ready (resp_ready)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Requester-side state: valid flag and held operands per lane.
  bit               va [NREQ];
  logic [WIDTH-1:0] aa [NREQ];
  logic [WIDTH-1:0] bb [NREQ];

  // Reference model state.
  bit m_vld;
  int m_id, m_sum, m_cout, m_ptr;
  int last_g;
  bit fair_on;
  int age [NREQ];

  // Values sampled at the most recent falling edge.
  logic [NREQ-1:0]  s_ready;
  logic             s_vld;
  logic [IDW-1:0]   s_id;
  logic [WIDTH-1:0] s_sum;
  logic             s_cout;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]              = va[i];
      req_a[i*WIDTH +: WIDTH]   = aa[i];
      req_b[i*WIDTH +: WIDTH]   = bb[i];
    end
  endtask

  task automatic model_reset();
    m_vld  = 1'b0;
    m_id   = 0;
    m_sum  = 0;
    m_cout = 0;
    m_ptr  = NREQ - 1;
    for (int i = 0; i < NREQ; i++) age[i] = 0;
  endtask

  task automatic set_lane(input int i, input int a, input int b);
    va[i] = 1'b1;
    aa[i] = WIDTH'(a);
    bb[i] = WIDTH'(b);
  endtask

  task automatic clear_lanes();
    for (int i = 0; i < NREQ; i++) va[i] = 1'b0;
  endtask

  // One clock: predict the grant, compare everything at the falling edge,
  // advance the model, then step past the rising edge.
  task automatic cycle();
    int  g;
    int  idx;
    int  full;
    bit  free;
    logic [NREQ-1:0] er;
    drive();
    @(negedge clk);
    free = !m_vld || resp_ready;
    g    = -1;
    if (!rst && free) begin
      for (int k = 1; k <= NREQ; k++) begin
        idx = (m_ptr + k) % NREQ;
        if (g < 0 && va[idx]) g = idx;
      end
    end
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    s_ready = req_ready;
    s_vld   = resp_valid;
    s_id    = resp_id;
    s_sum   = resp_sum;
    s_cout  = resp_cout;
    chk("req_ready", 32'(s_ready), 32'(er));
    chk("resp_valid", 32'(s_vld), 32'(m_vld));
    chk("resp_id", 32'(s_id), m_id);
    chk("resp_sum", 32'(s_sum), m_sum);
    chk("resp_cout", 32'(s_cout), m_cout);
    last_g = g;
    if (rst) begin
      model_reset();
    end else if (g >= 0) begin
      if (fair_on) chk("fair_age", 32'(age[g] < NREQ), 32'd1);
      for (int i = 0; i < NREQ; i++) begin
        if (i == g || !va[i]) age[i] = 0;
        else age[i]++;
      end
      full   = int'(aa[g]) + int'(bb[g]);
      m_sum  = full % (1 << WIDTH);
      m_cout = full / (1 << WIDTH);
      m_id   = g;
      m_vld  = 1'b1;
      m_ptr  = g;
    end else if (m_vld && resp_ready) begin
      m_vld = 1'b0;
    end
    @(posedge clk);
    #1;
    if (g >= 0) va[g] = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    resp_ready = 1'b0;
    fair_on    = 1'b0;
    last_g     = -1;
    for (int i = 0; i < NREQ; i++) begin
      va[i] = 1'b0;
      aa[i] = '0;
      bb[i] = '0;
    end
    drive();
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // Reset state with rst still high.
    cycle();
    chk("rst_state_vld", 32'(s_vld), 32'd0);
    chk("rst_state_sum", 32'(s_sum), 32'd0);
    chk("rst_state_id", 32'(s_id), 32'd0);

    // Single request on lane 2 right after reset.
    rst = 1'b0;
    resp_ready = 1'b1;
    set_lane(2, 9, 8);
    cycle();
    chk("t1_ready", 32'(s_ready), 32'h4);
    cycle();
    chk("t1_vld", 32'(s_vld), 32'd1);
    chk("t1_id", 32'(s_id), 32'd2);
    chk("t1_sum", 32'(s_sum), 32'h1);
    chk("t1_cout", 32'(s_cout), 32'd1);

    // All lanes continuously valid: grants rotate 0,1,2,3,0.
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int i = 0; i < NREQ; i++) set_lane(i, $urandom_range(0, 15), $urandom_range(0, 15));
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("t2_order", last_g, k % NREQ);
      if (last_g >= 0) set_lane(last_g, $urandom_range(0, 15), $urandom_range(0, 15));
    end

    // Backpressure with lanes 1 and 3 waiting.
    resp_ready = 1'b0;
    va[0] = 1'b0;
    va[2] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("bp_ready", 32'(s_ready), 32'd0);
    end
    resp_ready = 1'b1;
    cycle();
    chk("bp_grant", last_g, 32'd1);
    cycle();
    chk("bp_vld", 32'(s_vld), 32'd1);
    chk("bp_id", 32'(s_id), 32'd1);

    // Pointer wrap: after a lane-3 accept, lane 0 beats lane 3.
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    clear_lanes();
    set_lane(3, 5, 6);
    cycle();
    set_lane(0, 1, 2);
    set_lane(3, 7, 7);
    cycle();
    chk("wrap_grant", last_g, 32'd0);

    // Full-scale and zero sums.
    clear_lanes();
    cycle();
    set_lane(1, 15, 15);
    cycle();
    cycle();
    chk("fs_sum", 32'(s_sum), 32'hE);
    chk("fs_cout", 32'(s_cout), 32'd1);
    set_lane(1, 0, 0);
    cycle();
    cycle();
    chk("zero_sum", 32'(s_sum), 32'd0);
    chk("zero_cout", 32'(s_cout), 32'd0);

    // rst while a result is held and lanes are valid.
    for (int i = 0; i < NREQ; i++) set_lane(i, $urandom_range(0, 15), $urandom_range(0, 15));
    resp_ready = 1'b0;
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
    chk("mid_rst_ready", 32'(s_ready), 32'd0);
    rst = 1'b0;
    resp_ready = 1'b1;
    cycle();
    chk("mid_rst_vld", 32'(s_vld), 32'd0);
    chk("mid_rst_sum", 32'(s_sum), 32'd0);
    chk("mid_rst_first", last_g, 32'd0);

    // Randomized traffic with fairness tracking.
    fair_on = 1'b1;
    for (int i = 0; i < NREQ; i++) age[i] = 0;
    for (int n = 0; n < 400; n++) begin
      resp_ready = ($urandom_range(0, 9) < 7);
      rst = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (!va[i] && $urandom_range(0, 2) != 0)
          set_lane(i, $urandom_range(0, 15), $urandom_range(0, 15));
      end
      cycle();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
